// File: rtl/miriscv_pkg.sv
// miriscv_pkg: shared load/store funct3 encodings, LSU state type and bus lane helpers.
package miriscv_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} lsu_state_t;

    function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
        return size[1] ? 4'b1111 : size[0] ? 4'b0011 << off : 4'b0001 << off;
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] wdata);
        return size[1] ? wdata : size[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    endfunction

endpackage

// File: rtl/miriscv_lsu_load_fmt.sv
// miriscv_lsu_load_fmt: picks the addressed lane of a read word and sign/zero-extends it.
module miriscv_lsu_load_fmt
    import miriscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = 8'(rdata_i >> {off_i, 3'b000});
        h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            LS_B:    data_o = {{24{b[7]}}, b};
            LS_BU:   data_o = {24'd0, b};
            LS_H:    data_o = {{16{h[15]}}, h};
            LS_HU:   data_o = {16'd0, h};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv_lsu: single-outstanding load/store controller over a req/gnt/rvalid data bus,
// with alignment/funct3 traps, grant timeout and pipeline-kill handling.
module miriscv_lsu
    import miriscv_pkg::*;
#(
    parameter int GNT_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_kill_i,
    output logic        lsu_stall_o,
    output logic        lsu_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_misaligned_o,
    output logic        lsu_illegal_o,
    output logic        lsu_bus_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam int CW = GNT_TIMEOUT > 1 ? $clog2(GNT_TIMEOUT) : 1;

    lsu_state_t    state_q, state_d;
    logic          we_q, kill_q, kill_d;
    logic [2:0]    size_q;
    logic [1:0]    off_q;
    logic [3:0]    be_q;
    logic [31:0]   addr_q, wdata_q, fmt_data;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          idle, illegal, misal, req_ok, accept, timeout, rsp, dead;

    miriscv_lsu_load_fmt u_fmt (
        .rdata_i (data_rdata_i),
        .size_i  (size_q),
        .off_i   (off_q),
        .data_o  (fmt_data)
    );

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= lsu_we_i;
                size_q  <= lsu_size_i;
                off_q   <= lsu_addr_i[1:0];
                be_q    <= lsu_be(lsu_size_i, lsu_addr_i[1:0]);
                addr_q  <= {lsu_addr_i[31:2], 2'b00};
                wdata_q <= lsu_wdata(lsu_size_i, lsu_wdata_i);
            end
        end
    end

    always_comb begin
        idle    = state_q == IDLE;
        illegal = lsu_we_i ? lsu_size_i >= 3'b011 : lsu_size_i inside {3'b011, 3'b110, 3'b111};
        misal   = (lsu_size_i[1:0] == 2'b01 && lsu_addr_i[0]) ||
                  (lsu_size_i[1:0] == 2'b10 && lsu_addr_i[1:0] != 2'b00);
        req_ok  = idle && lsu_req_i && !lsu_kill_i;
        accept  = req_ok && !illegal && !misal;
        timeout = GNT_TIMEOUT != 0 && state_q == REQ && !data_gnt_i && cnt_q == CW'(GNT_TIMEOUT - 1);
        rsp     = data_rvalid_i && (state_q == WAIT_RSP || (state_q == REQ && data_gnt_i));
        // A killed transaction still drains its response, but nothing reaches the pipeline.
        dead    = lsu_kill_i || kill_q;
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = accept ? REQ : IDLE;
            REQ:      state_d = data_gnt_i ? (data_rvalid_i ? IDLE : WAIT_RSP) :
                                (lsu_kill_i || timeout) ? IDLE : REQ;
            WAIT_RSP: state_d = data_rvalid_i ? IDLE : WAIT_RSP;
            default:  state_d = IDLE;
        endcase
        kill_d           = state_d != IDLE && dead;
        cnt_d            = (state_q == REQ && !data_gnt_i) ? cnt_q + 1'b1 : '0;
        lsu_illegal_o    = req_ok && illegal;
        lsu_misaligned_o = req_ok && !illegal && misal;
        lsu_bus_err_o    = timeout && !lsu_kill_i;
        lsu_valid_o      = rsp && !dead;
        lsu_rdata_o      = (lsu_valid_o && !we_q) ? fmt_data : '0;
        lsu_stall_o      = accept || (!idle && !dead && !rsp);
        data_req_o       = state_q == REQ;
        data_we_o        = we_q;
        data_be_o        = be_q;
        data_addr_o      = addr_q;
        data_wdata_o     = wdata_q;
    end

endmodule

// File: tb/tb_miriscv_lsu.sv
// tb_miriscv_lsu: table-driven and randomized checks of miriscv_lsu against a byte-lane reference model.
module tb_miriscv_lsu;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        lsu_req_i, lsu_we_i, lsu_kill_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_stall_o, lsu_valid_o, lsu_misaligned_o, lsu_illegal_o, lsu_bus_err_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;
        int          rv;
        logic        ill;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd_exp;
    } vec_t;

    miriscv_lsu #(.GNT_TIMEOUT(4)) dut (
        .clk_i            (clk_i),
        .arstn_i          (arstn_i),
        .lsu_req_i        (lsu_req_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_kill_i       (lsu_kill_i),
        .lsu_stall_o      (lsu_stall_o),
        .lsu_valid_o      (lsu_valid_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_misaligned_o (lsu_misaligned_o),
        .lsu_illegal_o    (lsu_illegal_o),
        .lsu_bus_err_o    (lsu_bus_err_o),
        .data_req_o       (data_req_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_addr_o      (data_addr_o),
        .data_wdata_o     (data_wdata_o),
        .data_gnt_i       (data_gnt_i),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: access width in bytes drives lanes, replication and extension.
    function automatic vec_t model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input int gd, input int rv);
        vec_t v;
        int n, a;
        logic [31:0] m;
        v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.gd = gd; v.rv = rv;
        n = (size % 4 == 0) ? 1 : (size % 4 == 1) ? 2 : 4;
        a = int'(addr % 4);
        v.ill = we ? (size >= 3) : (size == 3 || size == 6 || size == 7);
        v.mis = !v.ill && (a % n != 0);
        for (int i = 0; i < 4; i++) begin
            v.be[i] = i >= a && i < a + n;
            v.wd[8*i +: 8] = wdata[8*(i % n) +: 8];
        end
        m = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        v.rd_exp = we ? 32'd0 : (rdata >> (8 * a)) & m;
        if (!we && size < 4 && n < 4 && v.rd_exp[8*n-1]) v.rd_exp = v.rd_exp | ~m;
        return v;
    endfunction

    task automatic idle_inputs();
        lsu_req_i = 0; lsu_kill_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
    endtask

    task automatic run(input vec_t v);
        int sc = 0;
        lsu_req_i = 1; lsu_we_i = v.we; lsu_size_i = v.size; lsu_addr_i = v.addr;
        lsu_wdata_i = v.wdata; data_rdata_i = v.rdata;
        @(negedge clk_i);
        chk("illegal", lsu_illegal_o, v.ill);
        chk("misaligned", lsu_misaligned_o, v.mis);
        chk("req_in_idle", data_req_o, 0);
        sc += lsu_stall_o;
        next_cycle();
        lsu_req_i = 0;
        lsu_wdata_i = $urandom;
        if (v.ill || v.mis) begin
            @(negedge clk_i);
            chk("trap_no_req", data_req_o, 0);
            chk("trap_stall", sc, 0);
            next_cycle();
            return;
        end
        for (int c = 0; c <= v.gd; c++) begin
            data_gnt_i = c == v.gd;
            data_rvalid_i = c == v.gd && v.rv == 0;
            @(negedge clk_i);
            chk("req", data_req_o, 1);
            chk("we", data_we_o, v.we);
            chk("be", data_be_o, v.be);
            chk("addr", data_addr_o, v.addr & 32'hFFFF_FFFC);
            chk("wdata", data_wdata_o, v.wd);
            chk("valid_req", lsu_valid_o, data_rvalid_i);
            if (data_rvalid_i) chk("rdata", lsu_rdata_o, v.rd_exp);
            sc += lsu_stall_o;
            next_cycle();
        end
        data_gnt_i = 0; data_rvalid_i = 0;
        for (int r = 1; r <= v.rv; r++) begin
            data_rvalid_i = r == v.rv;
            @(negedge clk_i);
            chk("req_wait", data_req_o, 0);
            chk("valid_wait", lsu_valid_o, data_rvalid_i);
            if (data_rvalid_i) chk("rdata", lsu_rdata_o, v.rd_exp);
            sc += lsu_stall_o;
            next_cycle();
        end
        data_rvalid_i = 0;
        chk("stall_cycles", sc, v.gd + v.rv + 1);
    endtask

    task automatic accept_lw(input logic [31:0] addr);
        lsu_req_i = 1; lsu_we_i = 0; lsu_size_i = 3'b010; lsu_addr_i = addr;
        next_cycle();
        lsu_req_i = 0;
    endtask

    vec_t tbl[14];

    initial begin
        arstn_i = 0;
        lsu_we_i = 0; lsu_size_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; data_rdata_i = 0;
        idle_inputs();
        tbl[0]  = '{0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 2, 1, 0, 0, 4'b1111, 32'h0, 32'hDEADBEEF};
        tbl[1]  = '{1, 3'b000, 32'h2003, 32'hA5, 32'h12345678, 1, 2, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        tbl[2]  = '{0, 3'b001, 32'h2002, 32'h0, 32'h80011234, 0, 1, 0, 0, 4'b1100, 32'h0, 32'hFFFF8001};
        tbl[3]  = '{0, 3'b101, 32'h2002, 32'h0, 32'h80011234, 3, 0, 0, 0, 4'b1100, 32'h0, 32'h00008001};
        tbl[4]  = '{0, 3'b010, 32'h1002, 32'h0, 32'h0, 0, 0, 0, 1, 4'b0000, 32'h0, 32'h0};
        tbl[5]  = '{1, 3'b011, 32'h1000, 32'h55, 32'h0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h0};
        tbl[6]  = '{0, 3'b110, 32'h1001, 32'h0, 32'h0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h0};
        tbl[7]  = '{0, 3'b000, 32'h3001, 32'h0, 32'h00008000, 1, 0, 0, 0, 4'b0010, 32'h0, 32'hFFFFFF80};
        tbl[8]  = '{0, 3'b100, 32'h3001, 32'h0, 32'h00008000, 0, 3, 0, 0, 4'b0010, 32'h0, 32'h00000080};
        tbl[9]  = '{1, 3'b001, 32'h4002, 32'hABCD1234, 32'hFFFFFFFF, 0, 0, 0, 0, 4'b1100, 32'h12341234, 32'h0};
        tbl[10] = '{1, 3'b010, 32'h5004, 32'hCAFEF00D, 32'h0, 3, 2, 0, 0, 4'b1111, 32'hCAFEF00D, 32'h0};
        tbl[11] = '{0, 3'b001, 32'h5001, 32'h0, 32'h0, 0, 0, 0, 1, 4'b0000, 32'h0, 32'h0};
        tbl[12] = '{1, 3'b100, 32'h5000, 32'h0, 32'h0, 0, 0, 1, 0, 4'b0000, 32'h0, 32'h0};
        tbl[13] = '{0, 3'b000, 32'h3003, 32'h0, 32'h7F000000, 0, 1, 0, 0, 4'b1000, 32'h0, 32'h0000007F};

        repeat (2) @(negedge clk_i);
        chk("rst_req", data_req_o, 0);
        chk("rst_stall", lsu_stall_o, 0);
        chk("rst_valid", lsu_valid_o, 0);
        chk("rst_be", data_be_o, 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_wdata", data_wdata_o, 0);
        chk("rst_rdata", lsu_rdata_o, 0);
        arstn_i = 1;
        next_cycle();

        foreach (tbl[i]) run(tbl[i]);

        // Grant never comes: request held exactly GNT_TIMEOUT cycles, error on the last one.
        accept_lw(32'h1000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("to_req", data_req_o, 1);
            chk("to_bus_err", lsu_bus_err_o, k == 3);
            chk("to_stall", lsu_stall_o, 1);
            next_cycle();
        end
        @(negedge clk_i);
        chk("to_idle_req", data_req_o, 0);
        chk("to_idle_err", lsu_bus_err_o, 0);
        chk("to_idle_stall", lsu_stall_o, 0);
        next_cycle();

        // Kill while requesting without grant: silent abort.
        accept_lw(32'h1000);
        lsu_kill_i = 1;
        @(negedge clk_i);
        chk("kreq_stall", lsu_stall_o, 0);
        chk("kreq_err", lsu_bus_err_o, 0);
        chk("kreq_valid", lsu_valid_o, 0);
        next_cycle();
        lsu_kill_i = 0;
        @(negedge clk_i);
        chk("kreq_dropped", data_req_o, 0);
        next_cycle();

        // Kill in WAIT_RSP: response drained, no valid, overlapping request refused.
        accept_lw(32'h1000);
        data_gnt_i = 1;
        next_cycle();
        data_gnt_i = 0; lsu_kill_i = 1;
        @(negedge clk_i);
        chk("kw_stall", lsu_stall_o, 0);
        chk("kw_valid", lsu_valid_o, 0);
        next_cycle();
        lsu_kill_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h11111111;
        lsu_req_i = 1; lsu_we_i = 0; lsu_size_i = 3'b010; lsu_addr_i = 32'h1000;
        @(negedge clk_i);
        chk("kw_rsp_valid", lsu_valid_o, 0);
        chk("kw_rsp_stall", lsu_stall_o, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        chk("kw_not_accepted", data_req_o, 0);
        next_cycle();
        run(model(0, 3'b010, 32'h1000, 32'h0, 32'h600DF00D, 1, 1));

        // Kill in IDLE: request ignored entirely.
        lsu_req_i = 1; lsu_kill_i = 1; lsu_we_i = 0; lsu_size_i = 3'b010; lsu_addr_i = 32'h1002;
        @(negedge clk_i);
        chk("kidle_stall", lsu_stall_o, 0);
        chk("kidle_mis", lsu_misaligned_o, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        chk("kidle_req", data_req_o, 0);
        next_cycle();

        // Asynchronous reset while requesting drops the request without a clock edge.
        accept_lw(32'h1000);
        @(negedge clk_i);
        chk("prerst_req", data_req_o, 1);
        #2 arstn_i = 0;
        #1 chk("async_rst_req", data_req_o, 0);
        @(negedge clk_i);
        arstn_i = 1;
        next_cycle();
        data_rvalid_i = 1;
        @(negedge clk_i);
        chk("postrst_req", data_req_o, 0);
        chk("idle_rvalid_ignored", lsu_valid_o, 0);
        chk("postrst_stall", lsu_stall_o, 0);
        next_cycle();
        data_rvalid_i = 0;

        for (int i = 0; i < 150; i++)
            run(model(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
